// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and scan state encoding for the 16 x 32
//               register file and its scan reader.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // Scan reader sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } scan_state_t;

  // Number of registers covered by an inclusive range, accounting for wrap
  function automatic int unsigned range_len(input logic [REG_ADDR_W-1:0] first_reg,
                                            input logic [REG_ADDR_W-1:0] last_reg);
    logic [REG_ADDR_W-1:0] span;
    span = last_reg - first_reg;
    return int'(span) + 1;
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regscan_idx_counter.sv
`default_nettype none
// ============================================================================
// Module      : regscan_idx_counter
// Description : Loadable modulo-2**ADDR_W index incrementer paired with a
//               remaining-count down-counter. is_last flags the final index.
// Revision    : 1.0 - initial release
// ============================================================================
module regscan_idx_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] idx,
  output logic              is_last
);

  logic [ADDR_W-1:0] remain;

  // Load the range on start; advance index and count down on each step.
  // Index arithmetic is naturally modulo 2**ADDR_W, so the top index wraps to 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      idx    <= '0;
      remain <= '0;
    end else if (load) begin
      idx    <= first_reg;
      remain <= last_reg - first_reg;
    end else if (step && (remain != '0)) begin
      idx    <= idx + ADDR_W'(1);
      remain <= remain - ADDR_W'(1);
    end
  end

  assign is_last = (remain == '0);

endmodule : regscan_idx_counter
`default_nettype wire

// File: rtl/regfile_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scan_reader
// Description : Read-side scan initiator for the register file. Walks an
//               inclusive (wrapping) register range, captures each word and
//               streams it on a valid/ready interface tagged with its index.
//               Optional macro REGSCAN_PARITY_EN adds out_par, the XOR-reduce
//               of out_data registered alongside it.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scan_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef REGSCAN_PARITY_EN
  ,
  output logic              out_par
`endif
);

  scan_state_t state;
  logic        cnt_load;
  logic        cnt_step;
  logic        cnt_last;
  logic        handshake;

  // A word leaves only when it is both offered and accepted
  assign handshake = (state == SEND) && out_valid && out_ready;
  assign cnt_load  = (state == IDLE) && start;
  assign cnt_step  = handshake && !cnt_last;

  // Index / remaining-count tracking; its index register is the read address
  regscan_idx_counter #(
    .ADDR_W (ADDR_W)
  ) u_idx_counter (
    .clk       (clk),
    .clr       (clr),
    .load      (cnt_load),
    .step      (cnt_step),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .idx       (ra),
    .is_last   (cnt_last)
  );

  // Scan sequencer with registered stream and status outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGSCAN_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          // rd_data is a combinational function of ra, so it is valid here
          out_data  <= rd_data;
          out_idx   <= ra;
          out_valid <= 1'b1;
`ifdef REGSCAN_PARITY_EN
          out_par   <= ^rd_data;
`endif
          state     <= SEND;
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (cnt_last) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= READ;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : regfile_scan_reader
`default_nettype wire

// File: tb/tb_regfile_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scan_reader
// Description : Directed self-checking bench for regfile_scan_reader with a
//               behavioural 16 x 32 register file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scan_reader;

  logic        clk;
  logic        clr;
  logic        start;
  logic [3:0]  first_reg;
  logic [3:0]  last_reg;
  logic [3:0]  ra;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef REGSCAN_PARITY_EN
  logic        out_par;
`endif

  logic [31:0] rf [16];
  int checks;
  int failures;

  assign rd_data = rf[ra];

  regfile_scan_reader #(
    .DATA_W (32),
    .ADDR_W (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .ra        (ra),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef REGSCAN_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point sits 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ra"},    32'(ra), 32'h0);
    chk({tag, "_data"},  out_data, 32'h0);
    chk({tag, "_idx"},   32'(out_idx), 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_done"},  32'(done), 32'h0);
`ifdef REGSCAN_PARITY_EN
    chk({tag, "_par"},   32'(out_par), 32'h0);
`endif
  endtask

  // Scan with out_ready held high: a word every 2 cycles, done after the last.
  // busy_pulse_k >= 0 pulses start (with a different range) during word k.
  task automatic scan_ready(input logic [3:0] f, input logic [3:0] l, input int n,
                            input int busy_pulse_k);
    logic [3:0] eidx;
    out_ready = 1'b1;
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("scan_busy_after_start", 32'(busy), 32'h1);
    chk("scan_ra_first", 32'(ra), 32'(f));
    for (int k = 0; k < n; k++) begin
      start = 1'b0;
      tick();
      eidx = f + 4'(k);
      chk("scan_valid", 32'(out_valid), 32'h1);
      chk("scan_idx", 32'(out_idx), 32'(eidx));
      chk("scan_data", out_data, rf[eidx]);
`ifdef REGSCAN_PARITY_EN
      chk("scan_par", 32'(out_par), 32'(^rf[eidx]));
`endif
      if (k == busy_pulse_k) begin
        start     = 1'b1;
        first_reg = f + 4'd7;
        last_reg  = f + 4'd7;
      end
      tick();
      start = 1'b0;
      chk("scan_valid_low", 32'(out_valid), 32'h0);
      chk("scan_done", 32'(done), (k == n - 1) ? 32'h1 : 32'h0);
    end
    tick();
    chk("scan_done_clear", 32'(done), 32'h0);
    chk("scan_busy_clear", 32'(busy), 32'h0);
    chk("scan_valid_idle", 32'(out_valid), 32'h0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clr       = 1'b0;
    start     = 1'b0;
    first_reg = 4'd0;
    last_reg  = 4'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 + 32'(i);
    rf[5] = 32'hDEADBEEF;

    tick();
    tick();
    chk_idle_outputs("reset");
    clr = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // Single register scan with explicit cycle timing
    out_ready = 1'b1;
    first_reg = 4'd5;
    last_reg  = 4'd5;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_valid_early", 32'(out_valid), 32'h0);
    tick();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_idx", 32'(out_idx), 32'h5);
    chk("single_data", out_data, 32'hDEADBEEF);
    tick();
    chk("single_done", 32'(done), 32'h1);
    chk("single_busy_fin", 32'(busy), 32'h1);
    chk("single_valid_low", 32'(out_valid), 32'h0);
    tick();
    chk("single_done_clear", 32'(done), 32'h0);
    chk("single_busy_clear", 32'(busy), 32'h0);

    // Full range 0..15
    rf[5] = 32'h105;
    scan_ready(4'd0, 4'd15, 16, -1);

    // Wrap 14,15,0,1 with an ignored start pulse during the second word
    scan_ready(4'd14, 4'd1, 4, 1);

    // Back-pressure: hold word at index 2 for 5 cycles
    out_ready = 1'b0;
    first_reg = 4'd2;
    last_reg  = 4'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_idx", 32'(out_idx), 32'h2);
      chk("bp_data", out_data, 32'h102);
      chk("bp_ra", 32'(ra), 32'h2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_accept_valid", 32'(out_valid), 32'h0);
    chk("bp_accept_ra", 32'(ra), 32'h3);
    tick();
    chk("bp_w1_valid", 32'(out_valid), 32'h1);
    chk("bp_w1_idx", 32'(out_idx), 32'h3);
    chk("bp_w1_data", out_data, 32'h103);
    tick();
    chk("bp_done", 32'(done), 32'h1);
    tick();
    chk("bp_busy_clear", 32'(busy), 32'h0);

    // Reset during the third word's SEND
    first_reg = 4'd0;
    last_reg  = 4'd7;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("rst_mid_valid_pre", 32'(out_valid), 32'h1);
    chk("rst_mid_idx_pre", 32'(out_idx), 32'h2);
    #2;
    clr = 1'b0;
    #1;
    chk_idle_outputs("rst_mid_async");
    tick();
    clr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_mid_no_done", 32'(done), 32'h0);
      chk("rst_mid_no_busy", 32'(busy), 32'h0);
    end
    scan_ready(4'd9, 4'd10, 2, -1);

`ifdef REGSCAN_PARITY_EN
    rf[4] = 32'h00000007;
    scan_ready(4'd4, 4'd4, 1, -1);
    chk("par_bit", 32'(out_par), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_scan_reader
`default_nettype wire
